wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Parametrised writeback arbiter for the execute stage. It collects results from NR_CH functional-unit
//  channels (ALU/branch, CSR, mult, VALU, LSU, FPU, CVXIF, ...) into one small FIFO per channel. It then
//  drains them onto NR_WB scoreboard writeback ports with round-robin fairness. Replaces the fixed
//  priority result mux, which had a single port; units now see backpressure instead of silent collisions.
// PARAMETERS
//  NR_CH          4   number of FU result channels (2..8)
//  NR_WB          2   number of scoreboard writeback ports (1..NR_CH)
//  DEPTH          2   entries per channel FIFO (power of two, 2..8)
//  XLEN          32   result width
//  TRANS_ID_BITS  3   scoreboard transaction id width
// PORTS
//  clk_i        in   1                     clock
//  rst_i        in   1                     synchronous reset, active high
//  flush_i      in   1                     pipeline flush; drop all buffered results
//  fu_valid_i   in   [NR_CH]               channel c presents a result
//  fu_ready_o   out  [NR_CH]               channel c FIFO can accept this cycle
//  fu_result_i  in   [NR_CH][XLEN]         result data
//  fu_tid_i     in   [NR_CH][TRANS_ID_BITS] scoreboard entry id
//  fu_ex_i      in   [NR_CH]               result carries an exception
//  fu_cause_i   in   [NR_CH][6]            exception cause (don't-care when fu_ex_i=0)
//  wb_valid_o   out  [NR_WB]               writeback port p valid (scoreboard never stalls)
//  wb_result_o  out  [NR_WB][XLEN]         writeback data
//  wb_tid_o     out  [NR_WB][TRANS_ID_BITS] writeback id
//  wb_ex_o      out  [NR_WB]               exception flag
//  wb_cause_o   out  [NR_WB][6]            exception cause
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge): all FIFOs empty, rr_ptr=0. Next cycle: fu_ready_o=all 1s,
//    wb_valid_o=0, and wb_result_o/tid/ex/cause=0.
//  - fu_ready_o[c] = (count[c] != DEPTH). This uses the registered count only, so a full FIFO refuses a
//    push even when it is popped in the same cycle (no pass-through). Push happens on fu_valid_i & fu_ready_o.
//  - Latency: a push at edge t is eligible for writeback in the cycle after t. There is no same-cycle bypass.
//  - Arbitration is combinational from the registered FIFO heads. Scan channels in the order rr_ptr, rr_ptr+1, ...
//    (mod NR_CH). Each non-empty channel is granted to the lowest free port, so port 0 gets the first grant.
//    At most one pop per channel per cycle and at most NR_WB grants per cycle.
//  - Unused ports: wb_valid_o=0 and data=0.
//  - rr_ptr update: (last granted channel + 1) mod NR_CH. It is unchanged when no grant occurs.
//  - Per-channel order is strictly FIFO. No ordering is guaranteed between channels.
//  - Flush (flush_i=1): wb_valid_o forced to 0 in the same cycle and no pushes accepted. All FIFOs are empty
//    next cycle and rr_ptr is kept. Flush takes priority over simultaneous push and pop.
//  - Reset takes priority over flush. Reset mid-stream discards all entries with no writeback.
//  - Pointer wrap-around: rd/wr pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  - fu_valid_i while fu_ready_o=0: not accepted. The FU must hold its result (valid/ready handshake).
// CONFIGURATION
//  `WB_ARB_PERF_EN defined: adds output perf_stall_o [NR_CH][32], a per-channel saturating counter.
//    It increments each cycle channel c is non-empty and not granted, excluding flush cycles.
//    It is cleared by rst_i only and saturates at 32'hFFFF_FFFF.
//  Not defined: the port and counters are absent. Functional behaviour is identical.
// STRUCTURE
//  - Shared package wb_arb_pkg: typedef wb_entry_t {result[XLEN], tid[TRANS_ID_BITS], ex, cause[6]}
//    and localparam CAUSE_W=6.
//  - Sub-module wb_arb_fifo: one per channel (generate loop). Ports: push, pop, flush, head entry, count, full, empty.
//  - The top level holds the round-robin grant logic, the port assignment mux and rr_ptr.
// TESTING (NR_CH=4, NR_WB=2, DEPTH=2 unless noted)
//  1. Reset: hold rst_i 2 cycles -> fu_ready_o=4'b1111, wb_valid_o=2'b00, and all wb data 0.
//  2. Push ch0 tid=1 res=0xA, ch2 tid=5 res=0xB in the same cycle -> the next cycle has port0={tid1,0xA}
//     and port1={tid5,0xB}, then rr_ptr=3.
//  3. Push ch1 on 3 consecutive cycles with no grants possible (ch0,ch2,ch3 kept full and NR_WB=1 to force ch1 losing) ->
//     fu_ready_o[1]=0 after 2 pushes. The 3rd is held by the FU and accepted only after ch1 has popped.
//  4. All 4 channels full, NR_WB=1 -> grants rotate ch0,ch1,ch2,ch3,ch0... and each channel's data comes out in push order.
//  5. Two entries in ch3, flush_i=1 while pushing ch0 -> wb_valid_o=0 that cycle, all FIFOs empty next cycle,
//     and the ch0 entry is never written back.
//  6. `WB_ARB_PERF_EN, NR_WB=1, ch0 and ch1 each hold 1 entry -> the first cycle grants ch0 (rr_ptr=0)
//     and perf_stall_o[1]=1, then ch1 is granted.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the execute-stage writeback arbiter.
//   CAUSE_W      : exception cause width
//   wb_entry_t   : one buffered writeback result (result, tid, ex, cause) at the
//                  default XLEN / TRANS_ID_BITS configuration
//   entry_width(): packed entry width for any XLEN / TRANS_ID_BITS setting
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int CAUSE_W  = 6;
  localparam int XLEN_DEF = 32;
  localparam int TID_DEF  = 3;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [TID_DEF-1:0]  tid;
    logic                ex;
    logic [CAUSE_W-1:0]  cause;
  } wb_entry_t;

  function automatic int entry_width(input int xlen, input int tid_bits);
    return xlen + tid_bits + 1 + CAUSE_W;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// -----------------------------------------------------------------------------
// wb_arb_fifo
// Small per-channel result FIFO. Registered head, no pass-through: a pushed
// entry becomes visible on head_o the cycle after the push edge.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the FIFO; beats any simultaneous push/pop
//   push_i, data_i write request (ignored when full)
//   pop_i          read request (ignored when empty)
//   head_o         oldest entry (stale contents when empty)
//   count_o        registered occupancy, 0..DEPTH
//   full_o,empty_o occupancy flags derived from count
// -----------------------------------------------------------------------------
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 42
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage holds data only; validity is carried entirely by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Collects functional-unit results into one FIFO per channel and drains them
// onto NR_WB scoreboard writeback ports with round-robin fairness.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  drop all buffered results, suppress writeback
//   fu_valid_i/fu_ready_o    per-channel valid/ready handshake
//   fu_result_i/tid/ex/cause per-channel result payload
//   wb_valid_o               per-port writeback valid (no stall from sink)
//   wb_result_o/tid/ex/cause per-port payload, zero when the port is idle
//   perf_stall_o             (WB_ARB_PERF_EN only) per-channel saturating
//                            count of cycles spent non-empty but not granted
// Build option: define WB_ARB_PERF_EN to add perf_stall_o and its counters.
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_CH         = 4,
  parameter int NR_WB         = 2,
  parameter int DEPTH         = 2,
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NR_CH-1:0]                      fu_valid_i,
  output logic [NR_CH-1:0]                      fu_ready_o,
  input  logic [NR_CH-1:0][XLEN-1:0]            fu_result_i,
  input  logic [NR_CH-1:0][TRANS_ID_BITS-1:0]   fu_tid_i,
  input  logic [NR_CH-1:0]                      fu_ex_i,
  input  logic [NR_CH-1:0][CAUSE_W-1:0]         fu_cause_i,
  output logic [NR_WB-1:0]                      wb_valid_o,
  output logic [NR_WB-1:0][XLEN-1:0]            wb_result_o,
  output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]   wb_tid_o,
  output logic [NR_WB-1:0]                      wb_ex_o,
  output logic [NR_WB-1:0][CAUSE_W-1:0]         wb_cause_o
`ifdef WB_ARB_PERF_EN
  ,output logic [NR_CH-1:0][31:0]               perf_stall_o
`endif
);

  localparam int ENTRY_W = entry_width(XLEN, TRANS_ID_BITS);
  localparam int PW      = $clog2(NR_CH);
  localparam int CW      = $clog2(DEPTH) + 1;

  logic [NR_CH-1:0][ENTRY_W-1:0] w_fu_entry;
  logic [NR_CH-1:0][ENTRY_W-1:0] w_head;
  logic [NR_CH-1:0][CW-1:0]      w_count;
  logic [NR_CH-1:0]              w_full;
  logic [NR_CH-1:0]              w_empty;
  logic [NR_CH-1:0]              w_push;
  logic [NR_CH-1:0]              w_pop;

  logic [NR_WB-1:0]              w_gnt_vld;
  logic [PW-1:0]                 w_gnt_ch [NR_WB];
  logic [PW-1:0]                 w_rr_nxt;
  logic [PW-1:0]                 r_rr_ptr;

  // Channel FIFOs
  for (genvar c = 0; c < NR_CH; c++) begin : g_ch
    assign w_fu_entry[c] = {fu_result_i[c], fu_tid_i[c], fu_ex_i[c], fu_cause_i[c]};
    // Ready looks at the registered count only: a full FIFO never accepts,
    // even if it is being popped this cycle.
    assign fu_ready_o[c] = (w_count[c] != CW'(DEPTH));
    assign w_push[c]     = fu_valid_i[c] & ~w_full[c];

    wb_arb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (w_push[c]),
      .pop_i   (w_pop[c]),
      .data_i  (w_fu_entry[c]),
      .head_o  (w_head[c]),
      .count_o (w_count[c]),
      .full_o  (w_full[c]),
      .empty_o (w_empty[c])
    );
  end

  // Round-robin scan starting at r_rr_ptr; each non-empty channel takes the
  // lowest free port until ports run out. A flush suppresses every grant so
  // neither writeback nor the pointer moves that cycle.
  always_comb begin
    int idx;
    int nport;
    w_gnt_vld = '0;
    w_pop     = '0;
    w_rr_nxt  = r_rr_ptr;
    for (int p = 0; p < NR_WB; p++) w_gnt_ch[p] = '0;
    nport = 0;
    for (int k = 0; k < NR_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NR_CH) idx = idx - NR_CH;
      if (!flush_i && nport < NR_WB) begin
        for (int c = 0; c < NR_CH; c++) begin
          if (c == idx && !w_empty[c]) begin
            w_pop[c] = 1'b1;
            for (int p = 0; p < NR_WB; p++) begin
              if (p == nport) begin
                w_gnt_vld[p] = 1'b1;
                w_gnt_ch[p]  = PW'(c);
              end
            end
            nport    = nport + 1;
            w_rr_nxt = (c == NR_CH - 1) ? '0 : PW'(c + 1);
          end
        end
      end
    end
  end

  // Port mux: idle ports drive all-zero payload.
  always_comb begin
    logic [ENTRY_W-1:0] sel;
    for (int p = 0; p < NR_WB; p++) begin
      sel = '0;
      for (int c = 0; c < NR_CH; c++) begin
        if (w_gnt_vld[p] && w_gnt_ch[p] == PW'(c)) sel = w_head[c];
      end
      wb_valid_o[p] = w_gnt_vld[p];
      {wb_result_o[p], wb_tid_o[p], wb_ex_o[p], wb_cause_o[p]} = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rr_ptr <= '0;
    else       r_rr_ptr <= w_rr_nxt;
  end

`ifdef WB_ARB_PERF_EN
  logic [NR_CH-1:0][31:0] r_perf;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counts waiting cycles; flush cycles are not contention and are skipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf <= '0;
    end else begin
      for (int c = 0; c < NR_CH; c++) begin
        if (!flush_i && !w_empty[c] && !w_pop[c]) r_perf[c] <= sat_inc(r_perf[c]);
      end
    end
  end

  assign perf_stall_o = r_perf;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  logic [3:0]         fu_valid;
  logic [3:0][31:0]   fu_result;
  logic [3:0][2:0]    fu_tid;
  logic [3:0]         fu_ex;
  logic [3:0][5:0]    fu_cause;

  // Two-port instance
  logic [3:0]         rdy2;
  logic [1:0]         v2;
  logic [1:0][31:0]   res2;
  logic [1:0][2:0]    tid2;
  logic [1:0]         ex2;
  logic [1:0][5:0]    cause2;

  // Single-port instance
  logic [3:0]         rdy1;
  logic [0:0]         v1;
  logic [0:0][31:0]   res1;
  logic [0:0][2:0]    tid1;
  logic [0:0]         ex1;
  logic [0:0][5:0]    cause1;
`ifdef WB_ARB_PERF_EN
  logic [3:0][31:0]   perf2;
  logic [3:0][31:0]   perf1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(.NR_CH(4), .NR_WB(2), .DEPTH(2), .XLEN(32), .TRANS_ID_BITS(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(rdy2), .fu_result_i(fu_result),
    .fu_tid_i(fu_tid), .fu_ex_i(fu_ex), .fu_cause_i(fu_cause),
    .wb_valid_o(v2), .wb_result_o(res2), .wb_tid_o(tid2),
    .wb_ex_o(ex2), .wb_cause_o(cause2)
`ifdef WB_ARB_PERF_EN
    ,.perf_stall_o(perf2)
`endif
  );

  wb_port_arbiter #(.NR_CH(4), .NR_WB(1), .DEPTH(2), .XLEN(32), .TRANS_ID_BITS(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(rdy1), .fu_result_i(fu_result),
    .fu_tid_i(fu_tid), .fu_ex_i(fu_ex), .fu_cause_i(fu_cause),
    .wb_valid_o(v1), .wb_result_o(res1), .wb_tid_o(tid1),
    .wb_ex_o(ex1), .wb_cause_o(cause1)
`ifdef WB_ARB_PERF_EN
    ,.perf_stall_o(perf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fu_valid  = '0;
    fu_result = '0;
    fu_tid    = '0;
    fu_ex     = '0;
    fu_cause  = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [2:0] t, input logic [31:0] r);
    fu_valid[c]  = 1'b1;
    fu_tid[c]    = t;
    fu_result[c] = r;
    fu_ex[c]     = 1'b0;
    fu_cause[c]  = '0;
  endtask

  // Expected payload for test 4: tid = 2*ch + n, result = 0x100*ch + n
  function automatic logic [31:0] t4_res(input int t);
    return 32'h100 * (t / 2) + (t % 2);
  endfunction

  initial begin
    int seq4 [7];
    seq4 = '{2, 4, 6, 1, 3, 5, 7};
    rst = 1'b1;
    clear_inputs();

    // 1. Reset state
    do_reset();
    check("rst_ready2", rdy2, 4'hF);
    check("rst_ready1", rdy1, 4'hF);
    check("rst_valid2", v2, 2'b00);
    check("rst_valid1", v1, 1'b0);
    check("rst_res2", res2, 64'h0);
    check("rst_meta2", {tid2, ex2, cause2}, 0);
    check("rst_data1", {res1, tid1, ex1, cause1}, 0);
    check("rst_rr2", u_dut2.r_rr_ptr, 0);

    // 2. Two pushes, two ports, same cycle
    set_ch(0, 3'd1, 32'hA);
    set_ch(2, 3'd5, 32'hB);
    fu_ex[2]    = 1'b1;
    fu_cause[2] = 6'd13;
    tick();
    clear_inputs();
    check("t2_valid", v2, 2'b11);
    check("t2_tid", tid2, {3'd5, 3'd1});
    check("t2_res", res2, {32'hB, 32'hA});
    check("t2_ex", ex2, 2'b10);
    check("t2_cause", cause2, {6'd13, 6'd0});
    tick();
    check("t2_rr", u_dut2.r_rr_ptr, 3);
    check("t2_drained", v2, 2'b00);

    // Reset mid-stream discards the buffered entry
    set_ch(1, 3'd6, 32'h66);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_valid2", v2, 2'b00);
    check("rstmid_ready2", rdy2, 4'hF);

    // 4. All channels loaded, single port: rotation plus per-channel order
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 3'(2 * c), 32'h100 * c);
    tick();
    check("t4_ready", rdy1, 4'hF);
    check("t4_tid0", tid1, 0);
    check("t4_res0", res1, 32'h0);
    for (int c = 0; c < 4; c++) set_ch(c, 3'(2 * c + 1), 32'h100 * c + 1);
    tick();
    clear_inputs();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t4_valid%0d", i + 1), v1, 1'b1);
      check($sformatf("t4_tid%0d", i + 1), tid1, seq4[i]);
      check($sformatf("t4_res%0d", i + 1), res1, t4_res(seq4[i]));
      tick();
    end
    check("t4_empty", v1, 1'b0);

    // 3. Backpressure on ch1 with single port
    do_reset();
    set_ch(0, 3'd0, 32'hA0);
    set_ch(1, 3'd2, 32'hB0);
    tick();
    check("t3_gnt_a0", tid1, 0);
    set_ch(0, 3'd1, 32'hA1);
    set_ch(1, 3'd3, 32'hB1);
    tick();
    fu_valid[0] = 1'b0;
    set_ch(1, 3'd4, 32'hB2);
    check("t3_full", rdy1[1], 1'b0);
    check("t3_gnt_b0", tid1, 2);
    tick();
    check("t3_ready_again", rdy1[1], 1'b1);
    check("t3_gnt_a1", tid1, 1);
    tick();
    clear_inputs();
    check("t3_gnt_b1", tid1, 3);
    tick();
    check("t3_gnt_b2", tid1, 4);
    check("t3_res_b2", res1, 32'hB2);
    tick();
    check("t3_empty", v1, 1'b0);

    // 5. Flush with two entries in ch3 and a concurrent push on ch0
    do_reset();
    set_ch(0, 3'd1, 32'h1);
    set_ch(1, 3'd2, 32'h2);
    set_ch(3, 3'd3, 32'h3);
    tick();
    clear_inputs();
    set_ch(3, 3'd4, 32'h4);
    tick();
    clear_inputs();
    check("t5_ch3_full", rdy1[3], 1'b0);
    flush = 1'b1;
    set_ch(0, 3'd5, 32'h5);
    #1;
    check("t5_flush_valid1", v1, 1'b0);
    check("t5_flush_valid2", v2, 2'b00);
    tick();
    clear_inputs();
    check("t5_ready", rdy1, 4'hF);
    check("t5_valid_after", v1, 1'b0);
    check("t5_rr_kept", u_dut1.r_rr_ptr, 1);
    tick();
    check("t5_no_wb", v1, 1'b0);

`ifdef WB_ARB_PERF_EN
    // 6. Stall counter
    do_reset();
    set_ch(0, 3'd1, 32'h10);
    set_ch(1, 3'd2, 32'h20);
    tick();
    clear_inputs();
    check("t6_gnt_ch0", tid1, 1);
    check("t6_perf1_pre", perf1[1], 0);
    tick();
    check("t6_gnt_ch1", tid1, 2);
    check("t6_perf1", perf1[1], 1);
    check("t6_perf0", perf1[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
